// File: rtl/ddr_burst_reader_pkg.sv
// Shared widths (hyper_para defaults) and FSM types for the DDR burst-read client.
// DDR_RD_MAX_BURST / DDR_RD_FIFO_DEPTH are the defaults used by ddr_burst_reader.
`ifndef HYPER_PARA_DEFS
`define HYPER_PARA_DEFS
`define DATA_WIDTH 64
`define ADDR_SIZE 32
`define LEN_WIDTH 8
`define DDR_RD_MAX_BURST 16
`define DDR_RD_FIFO_DEPTH 64
`endif

package ddr_burst_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_DONE     = 3'd4
  } rd_state_e;

  function automatic logic [`LEN_WIDTH-1:0] min_len(input logic [31:0] remaining,
                                                    input logic [31:0] max_burst);
    if (remaining > max_burst) return max_burst[`LEN_WIDTH-1:0];
    else return remaining[`LEN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ddr_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Writes while full and reads while empty are ignored.
module ddr_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != CW'(DEPTH));
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/ddr_burst_reader.sv
// Splits a linear read transfer into DDR bursts and buffers returned beats in a FIFO.
// Optional macro DDR_RD_BEAT_CHECK_EN adds per-burst beat counting and the sticky err_beat flag.
//
// state    | meaning
// IDLE     | waiting for xfer_start
// CHECK    | next burst length chosen; wait for FIFO room (or finish if nothing left)
// REQ      | one-cycle burst request
// WAIT_FIN | collecting beats until burst_read_finish
// DONE     | one-cycle xfer_done pulse
module ddr_burst_reader
  import ddr_burst_reader_pkg::*;
#(
  parameter int MAX_BURST  = `DDR_RD_MAX_BURST,
  parameter int FIFO_DEPTH = `DDR_RD_FIFO_DEPTH,
  parameter int XFER_WIDTH = 20
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic                   xfer_start,
  input  logic [`ADDR_SIZE-1:0]  xfer_addr,
  input  logic [XFER_WIDTH-1:0]  xfer_words,
  output logic                   xfer_busy,
  output logic                   xfer_done,
  output logic                   burst_read_req,
  output logic [`ADDR_SIZE-1:0]  burst_read_addr,
  output logic [`LEN_WIDTH-1:0]  burst_read_len,
  input  logic [`DATA_WIDTH-1:0] burst_read_data,
  input  logic                   burst_read_valid,
  input  logic                   burst_read_finish,
  output logic [`DATA_WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   err_beat
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e             state_q, state_d;
  logic [`ADDR_SIZE-1:0] addr_q, addr_d;
  logic [XFER_WIDTH-1:0] rem_q, rem_d;
  logic [XFER_WIDTH-1:0] rem_after;
  logic [`LEN_WIDTH-1:0] len_q, len_d;
  logic [`LEN_WIDTH-1:0] blen;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_room;
  logic                  fifo_wr;

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
    end
  end

  // Only one burst is ever in flight, so the live count is a safe room estimate.
  always_comb begin
    blen      = min_len(32'(rem_q), 32'(MAX_BURST));
    fifo_room = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(blen);
    rem_after = rem_q - XFER_WIDTH'(len_q);
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    case (state_q)
      S_IDLE: begin
        if (xfer_start) begin
          addr_d  = xfer_addr;
          rem_d   = xfer_words;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // A zero-word transfer passes through here without a request.
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (fifo_room) begin
          len_d   = blen;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT_FIN;
      S_WAIT_FIN: begin
        if (burst_read_finish) begin
          addr_d  = addr_q + `ADDR_SIZE'({len_q, 3'b000});
          rem_d   = rem_after;
          state_d = (rem_after == '0) ? S_DONE : S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xfer_busy      = 1'b0;
    xfer_done      = 1'b0;
    burst_read_req = 1'b0;
    fifo_wr        = 1'b0;
    case (state_q)
      S_CHECK:    xfer_busy = 1'b1;
      S_REQ: begin
        xfer_busy      = 1'b1;
        burst_read_req = 1'b1;
      end
      S_WAIT_FIN: begin
        xfer_busy = 1'b1;
        fifo_wr   = burst_read_valid;
      end
      S_DONE:     xfer_done = 1'b1;
      default:    xfer_busy = 1'b0;
    endcase
  end

  assign burst_read_addr = addr_q;
  assign burst_read_len  = len_q;

  ddr_rd_fifo #(
    .WIDTH (`DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (user_clk),
    .rst_n    (user_rst_n),
    .wr_en    (fifo_wr),
    .wr_data  (burst_read_data),
    .rd_en    (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count)
  );

`ifdef DDR_RD_BEAT_CHECK_EN
  logic [`LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [`LEN_WIDTH-1:0] beats_seen;
  logic                  err_q, err_d;

  // beats_seen includes a beat landing in the same cycle as finish.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    beats_seen = beat_cnt_q + `LEN_WIDTH'(fifo_wr);
    if (state_q == S_REQ) begin
      beat_cnt_d = '0;
    end else if (state_q == S_WAIT_FIN) begin
      beat_cnt_d = beats_seen;
      if (burst_read_finish && (beats_seen != len_q)) err_d = 1'b1;
      if (fifo_wr && (fifo_count == CW'(FIFO_DEPTH))) err_d = 1'b1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_beat = err_q;
`else
  assign err_beat = 1'b0;
`endif

endmodule
